linecard_ingress_arbiter: RTL and testbench

- Parametrised, packet-atomic round-robin arbiter that merges NUM_PORTS AXI-Stream ingress channels onto one fabric-side stream.
- Sits between the per-port line card ingress FIFOs and the MAC lookup / crossbar stage.
- Tags each packet with its source port.
- Supports a per-port enable mask and a per-port VLAN tag; counts forwarded packets per port.

---
 rtl/linecard_pkg.sv | 18 +
 rtl/linecard_rr_picker.sv | 32 +++
 rtl/linecard_ingress_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_linecard_ingress_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/linecard_pkg.sv
// Shared types and constants for the line card ingress arbiter.
package linecard_pkg;

    localparam int MAX_LINECARD_PORTS = 32;
    localparam int VLAN_WIDTH         = 12;
    localparam int TUSER_ERR_BIT      = 12;
    localparam int TUSER_WIDTH        = TUSER_ERR_BIT + 1;

    typedef logic [VLAN_WIDTH-1:0] vlan_t;

    // DISCARD: a watchdog error beat is on the output, waiting to drain.
    typedef enum logic [1:0] {
        IDLE,
        FORWARD,
        DISCARD
    } linecard_arb_state_t;

endpackage

// File: rtl/linecard_rr_picker.sv
// Combinational round-robin picker: first requester strictly after ptr_i,
// searching upward with wrap at NUM_PORTS. Indices >= NUM_PORTS never occur.
module linecard_rr_picker #(
    parameter int NUM_PORTS = 24,
    parameter int PORT_BITS = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_BITS-1:0] ptr_i,
    output logic                 grant_valid_o,
    output logic [PORT_BITS-1:0] grant_idx_o
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int idx;
        logic [PORT_BITS-1:0] idx_b;
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        idx_b         = '0;
        for (int off = NUM_PORTS; off >= 1; off--) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            idx_b = PORT_BITS'(idx);
            if (req_i[idx_b]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx_b;
            end
        end
    end

endmodule

// File: rtl/linecard_ingress_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS AXI-Stream ingress channels
// onto one fabric stream, tagged with source port (m_tdest) and VLAN (m_tuser).
// Optional stall watchdog: define LINECARD_ARB_WATCHDOG_EN.
module linecard_ingress_arbiter
    import linecard_pkg::*;
#(
    parameter int NUM_PORTS  = 24,
    parameter int DATA_WIDTH = 64,
    parameter int PORT_BITS  = $clog2(NUM_PORTS),
    parameter int CNT_WIDTH  = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                            clk_fabric,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            port_en,
    input  logic [NUM_PORTS*VLAN_WIDTH-1:0] port_vlan,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_tkeep,
    output logic                            m_tlast,
    output logic [PORT_BITS-1:0]            m_tdest,
    output logic [TUSER_WIDTH-1:0]          m_tuser,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count
);

    localparam int KEEP_W = DATA_WIDTH / 8;

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_LINECARD_PORTS || (DATA_WIDTH % 8) != 0 || TIMEOUT < 1)
    begin : g_bad_cfg
        $error("linecard_ingress_arbiter: unsupported parameter set");
    end

    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] s_data_a;
    logic [NUM_PORTS-1:0][KEEP_W-1:0]     s_keep_a;
    vlan_t [NUM_PORTS-1:0]                vlan_a;
    assign s_data_a = s_tdata;
    assign s_keep_a = s_tkeep;
    assign vlan_a   = port_vlan;

    linecard_arb_state_t                 state_q;
    logic [PORT_BITS-1:0]                grant_q, ptr_q;
    vlan_t                               vlan_q;
    logic                                m_tvalid_q, m_tlast_q;
    logic [DATA_WIDTH-1:0]               m_tdata_q;
    logic [KEEP_W-1:0]                   m_tkeep_q;
    logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] cnt_q;

    logic [NUM_PORTS-1:0] disc_mask;
    logic                 wd_lim, err_bit;

`ifdef LINECARD_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]      wd_q;
    logic [NUM_PORTS-1:0] disc_q;
    logic                 err_q, wd_hit;
    assign disc_mask = disc_q;
    assign wd_lim    = (wd_q == WD_W'(TIMEOUT));
    assign err_bit   = err_q;
`else
    assign disc_mask = '0;
    assign wd_lim    = 1'b0;
    assign err_bit   = 1'b0;
`endif

    // Ports being flushed after a timeout do not compete for the grant.
    logic [NUM_PORTS-1:0] req;
    logic                 pick_vld;
    logic [PORT_BITS-1:0] pick_idx;
    assign req = s_tvalid & port_en & ~disc_mask;

    linecard_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_picker (
        .req_i         (req),
        .ptr_i         (ptr_q),
        .grant_valid_o (pick_vld),
        .grant_idx_o   (pick_idx)
    );

    // Once the tlast beat sits in the output register, stop taking input so
    // the next packet from the same port cannot slip into this grant.
    logic out_free, last_pend, out_fire, fwd_ready, in_fire;
    assign out_free  = !m_tvalid_q || m_tready;
    assign last_pend = m_tvalid_q && m_tlast_q;
    assign out_fire  = m_tvalid_q && m_tready;
    assign fwd_ready = (state_q == FORWARD) && out_free && !last_pend && !wd_lim;
    assign in_fire   = fwd_ready && s_tvalid[grant_q];

`ifdef LINECARD_ARB_WATCHDOG_EN
    assign wd_hit = (state_q == FORWARD) && wd_lim && out_free && !last_pend;
`endif

    // Ready only toward the granted port (plus any port being flushed).
    always_comb begin
        s_tready = disc_mask;
        if (fwd_ready) s_tready[grant_q] = 1'b1;
        if (rst) s_tready = '0;
    end

    assign m_tvalid  = m_tvalid_q;
    assign m_tdata   = m_tdata_q;
    assign m_tkeep   = m_tkeep_q;
    assign m_tlast   = m_tlast_q;
    assign m_tdest   = grant_q;
    assign pkt_count = cnt_q;

    // Sideband: VLAN in the low bits, truncation flag on top.
    always_comb begin
        m_tuser                    = '0;
        m_tuser[VLAN_WIDTH-1:0]    = vlan_q;
        m_tuser[TUSER_ERR_BIT]     = err_bit;
    end

    // Arbitration FSM, output skid register and per-port packet counters.
    always_ff @(posedge clk_fabric) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= PORT_BITS'(NUM_PORTS - 1);
            vlan_q     <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            cnt_q      <= '0;
`ifdef LINECARD_ARB_WATCHDOG_EN
            wd_q       <= '0;
            disc_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
`ifdef LINECARD_ARB_WATCHDOG_EN
            for (int p = 0; p < NUM_PORTS; p++)
                if (disc_q[p] && s_tvalid[p] && s_tlast[p]) disc_q[p] <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_idx;
                        vlan_q  <= vlan_a[pick_idx];
                        state_q <= FORWARD;
`ifdef LINECARD_ARB_WATCHDOG_EN
                        wd_q    <= '0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                FORWARD: begin
                    if (in_fire) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= s_data_a[grant_q];
                        m_tkeep_q  <= s_keep_a[grant_q];
                        m_tlast_q  <= s_tlast[grant_q];
                    end else if (out_fire) begin
                        m_tvalid_q <= 1'b0;
                    end
                    if (out_fire && m_tlast_q) begin
                        cnt_q[grant_q] <= cnt_q[grant_q] + CNT_WIDTH'(1);
                        ptr_q          <= grant_q;
                        state_q        <= IDLE;
                    end
`ifdef LINECARD_ARB_WATCHDOG_EN
                    if (in_fire)
                        wd_q <= '0;
                    else if (!s_tvalid[grant_q] && !last_pend && !wd_lim)
                        wd_q <= wd_q + 1'b1;
                    if (wd_hit) begin
                        m_tvalid_q      <= 1'b1;
                        m_tdata_q       <= '0;
                        m_tkeep_q       <= '0;
                        m_tlast_q       <= 1'b1;
                        err_q           <= 1'b1;
                        disc_q[grant_q] <= 1'b1;
                        wd_q            <= '0;
                        state_q         <= DISCARD;
                    end
`endif
                end
                DISCARD: begin
                    if (out_fire) begin
                        m_tvalid_q <= 1'b0;
                        ptr_q      <= grant_q;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_linecard_ingress_arbiter.sv
// Scoreboard bench for linecard_ingress_arbiter (default build, 24 ports).
module tb_linecard_ingress_arbiter;

    localparam int NP = 24;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int PB = 5;
    localparam int CW = 32;

    logic clk_fabric = 1'b0;
    always #5 clk_fabric = ~clk_fabric;

    logic                rst;
    logic [NP-1:0]       port_en;
    logic [NP*12-1:0]    port_vlan;
    logic [NP-1:0]       s_tvalid, s_tready, s_tlast;
    logic [NP*DW-1:0]    s_tdata;
    logic [NP*KW-1:0]    s_tkeep;
    logic                m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]       m_tdata;
    logic [KW-1:0]       m_tkeep;
    logic [PB-1:0]       m_tdest;
    logic [12:0]         m_tuser;
    logic [NP*CW-1:0]    pkt_count;

    linecard_ingress_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk_fabric (clk_fabric), .rst (rst),
        .port_en (port_en), .port_vlan (port_vlan),
        .s_tvalid (s_tvalid), .s_tready (s_tready), .s_tdata (s_tdata),
        .s_tkeep (s_tkeep), .s_tlast (s_tlast),
        .m_tvalid (m_tvalid), .m_tready (m_tready), .m_tdata (m_tdata),
        .m_tkeep (m_tkeep), .m_tlast (m_tlast), .m_tdest (m_tdest),
        .m_tuser (m_tuser), .pkt_count (pkt_count)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } txb_t;

    txb_t         txq[NP][$];
    logic [127:0] expq[$];
    int           n_tests = 0, n_fail = 0, out_cnt = 0, gaps = 0;
    bit           bp_mode = 1'b0, in_pkt = 1'b0, hold_pend = 1'b0;
    logic [127:0] hold_val;

    function automatic logic [127:0] pack_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                               input logic l, input logic [PB-1:0] dst,
                                               input logic [11:0] v, input logic e);
        return {37'b0, e, v, dst, l, k, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, want);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int p);
        return pkt_count[p*CW +: CW];
    endfunction

    // Queue a packet at port p; with want_out, also predict its output beats.
    task automatic send_pkt(input int p, input int len, input bit want_out = 1'b1);
        for (int i = 0; i < len; i++) begin
            txb_t b;
            b.d = {$urandom, $urandom};
            b.l = (i == len - 1);
            b.k = b.l ? 8'($urandom_range(1, 255)) : 8'hFF;
            txq[p].push_back(b);
            if (want_out)
                expq.push_back(pack_beat(b.d, b.k, b.l, PB'(p), port_vlan[p*12 +: 12], 1'b0));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        expq.delete();
        for (int p = 0; p < NP; p++) txq[p].delete();
        repeat (2) @(posedge clk_fabric);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (expq.size() != 0 && n < max_cyc) begin
            @(posedge clk_fabric); #1;
            n++;
        end
        chk(tag, expq.size(), 0);
        repeat (3) @(posedge clk_fabric);
        #1;
    endtask

    // Source drivers, sink and output monitor: drive at negedge, sample +1,
    // retire accepted source beats at the following posedge.
    initial begin : bfm
        logic [NP-1:0] fire;
        logic [127:0]  act;
        forever begin
            @(negedge clk_fabric);
            for (int p = 0; p < NP; p++) begin
                if (txq[p].size() != 0) begin
                    s_tvalid[p]          = 1'b1;
                    s_tdata[p*DW +: DW]  = txq[p][0].d;
                    s_tkeep[p*KW +: KW]  = txq[p][0].k;
                    s_tlast[p]           = txq[p][0].l;
                end else begin
                    s_tvalid[p] = 1'b0;
                    s_tlast[p]  = 1'b0;
                end
            end
            m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            fire = s_tvalid & s_tready;
            act  = pack_beat(m_tdata, m_tkeep, m_tlast, m_tdest, m_tuser[11:0], m_tuser[12]);
            if (rst) begin
                hold_pend = 1'b0;
                in_pkt    = 1'b0;
            end else begin
                if (hold_pend) chk("hold", act, hold_val);
                if (in_pkt && !m_tvalid && !bp_mode) gaps++;
                if (m_tvalid && m_tready) begin
                    if (expq.size() == 0) chk("extra_beat", 1, 0);
                    else chk("beat", act, expq.pop_front());
                    out_cnt++;
                    in_pkt = !m_tlast;
                end
                hold_pend = m_tvalid && !m_tready;
                hold_val  = act;
            end
            @(posedge clk_fabric);
            for (int p = 0; p < NP; p++)
                if (fire[p] && txq[p].size() != 0) void'(txq[p].pop_front());
        end
    end

    initial begin : guard
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int base, n;
        rst = 1'b1; port_en = '1; m_tready = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0;
        for (int p = 0; p < NP; p++) port_vlan[p*12 +: 12] = 12'(100 + p);
        port_vlan[1*12 +: 12] = 12'd69;

        // Reset state
        repeat (3) @(posedge clk_fabric);
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tdest", m_tdest, 0);
        chk("rst_m_tuser", m_tuser, 0);
        chk("rst_cnt", |pkt_count, 0);
        rst = 1'b0;
        @(posedge clk_fabric); #1;

        // Single source, 3 x 16 beats, VLAN 69
        gaps = 0;
        for (int i = 0; i < 3; i++) send_pkt(1, 16);
        wait_drain("t1_drain", 400);
        chk("t1_cnt1", cnt_of(1), 3);
        chk("t1_gaps", gaps, 0);

        // Two continuous requesters alternate 1,2,1,2
        do_reset();
        gaps = 0;
        for (int i = 0; i < 4; i++) begin
            send_pkt(1, 4);
            send_pkt(2, 4);
        end
        wait_drain("t2_drain", 400);
        chk("t2_cnt1", cnt_of(1), 4);
        chk("t2_cnt2", cnt_of(2), 4);
        chk("t2_gaps", gaps, 0);

        // Random backpressure over a 64-beat packet
        bp_mode = 1'b1;
        send_pkt(3, 64);
        wait_drain("t3_drain", 1000);
        bp_mode = 1'b0;
        chk("t3_cnt3", cnt_of(3), 1);

        // Wrap-around from pointer 23, then masking port 0
        do_reset();
        send_pkt(0, 3);
        send_pkt(22, 3);
        wait_drain("t4_drain_a", 200);
        chk("t4_cnt0", cnt_of(0), 1);
        chk("t4_cnt22", cnt_of(22), 1);
        port_en[0] = 1'b0;
        send_pkt(0, 3, 1'b0);
        send_pkt(22, 3);
        wait_drain("t4_drain_b", 200);
        repeat (20) @(posedge clk_fabric);
        #1;
        chk("t4_p0_held", txq[0].size(), 3);
        chk("t4_cnt0_masked", cnt_of(0), 1);
        chk("t4_cnt22_b", cnt_of(22), 2);
        txq[0].delete();
        port_en[0] = 1'b1;

        // Reset on beat 5 of a 10-beat packet
        do_reset();
        base = out_cnt;
        send_pkt(5, 10);
        n = 0;
        while (out_cnt < base + 4 && n < 200) begin
            @(posedge clk_fabric); #1;
            n++;
        end
        chk("t5_reached", out_cnt >= base + 4, 1);
        rst = 1'b1;
        expq.delete();
        txq[5].delete();
        @(posedge clk_fabric); #1;
        rst = 1'b0;
        chk("t5_m_tvalid", m_tvalid, 0);
        chk("t5_cnt_zero", |pkt_count, 0);
        chk("t5_s_tready", s_tready, 0);
        send_pkt(4, 2);
        send_pkt(7, 2);
        wait_drain("t5_drain", 200);
        chk("t5_cnt4", cnt_of(4), 1);
        chk("t5_cnt7", cnt_of(7), 1);
        chk("t5_cnt5", cnt_of(5), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
